// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu_uop_sequencer: micro-PC and flow controller for dzcpu (ports iClock/iReset/iStall/iMop*/iFlow*/iCbFlowIdx/iFlagZ in; oMop/oUopAddr/oPcInc/oFlagsUpdate/oUopValid/oEof/oOverrun out; DZCPU_SEQ_BREAKPOINT_EN adds iBreakMop/iBreakEn/iResume/oBreak opcode breakpoint)
module dzcpu_uop_sequencer #(
  parameter int UPC_W  = 8,
  parameter int FLOW_W = 4
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iStall,
  input  logic [7:0]        iMopData,
  input  logic              iMopValid,
  input  logic [UPC_W-1:0]  iFlowIdx,
  input  logic [UPC_W-1:0]  iCbFlowIdx,
  input  logic [FLOW_W-1:0] iFlowCtl,
  input  logic              iFlagZ,
  output logic [7:0]        oMop,
  output logic [UPC_W-1:0]  oUopAddr,
  output logic              oPcInc,
  output logic              oFlagsUpdate,
  output logic              oUopValid,
  output logic              oEof,
  output logic              oOverrun
`ifdef DZCPU_SEQ_BREAKPOINT_EN
  ,
  input  logic [7:0]        iBreakMop,
  input  logic              iBreakEn,
  input  logic              iResume,
  output logic              oBreak
`endif
);
  localparam logic [FLOW_W-1:0] F_INC        = FLOW_W'(1);
  localparam logic [FLOW_W-1:0] F_EOF        = FLOW_W'(2);
  localparam logic [FLOW_W-1:0] F_INC_EOF    = FLOW_W'(3);
  localparam logic [FLOW_W-1:0] F_INC_EOF_Z  = FLOW_W'(4);
  localparam logic [FLOW_W-1:0] F_INC_EOF_NZ = FLOW_W'(5);
  localparam logic [FLOW_W-1:0] F_JCB        = FLOW_W'(6);
  localparam logic [FLOW_W-1:0] F_EOF_FU     = FLOW_W'(7);
  localparam logic [FLOW_W-1:0] F_INC_EOF_FU = FLOW_W'(8);
  localparam logic [FLOW_W-1:0] F_UPD_FLAGS  = FLOW_W'(9);
  typedef enum logic [2:0] {FETCH, DECODE, CBDECODE, EXEC, BRK} state_t;
  state_t state;
  logic exec, z_end, is_eof, is_inc, is_fu, is_jcb;
  logic [UPC_W:0] inc_addr;
  always_comb begin
    exec = (state == EXEC) && !iStall;
    z_end = (iFlowCtl == F_INC_EOF_Z && iFlagZ) || (iFlowCtl == F_INC_EOF_NZ && !iFlagZ);
    is_eof = (iFlowCtl inside {F_EOF, F_INC_EOF, F_EOF_FU, F_INC_EOF_FU}) || z_end;
    is_inc = iFlowCtl inside {F_INC, F_INC_EOF, F_INC_EOF_Z, F_INC_EOF_NZ, F_JCB, F_INC_EOF_FU};
    is_fu = iFlowCtl inside {F_EOF_FU, F_INC_EOF_FU, F_UPD_FLAGS};
    is_jcb = iFlowCtl == F_JCB;
    inc_addr = {1'b0, oUopAddr} + 1'b1;
    oUopValid = exec;
    oPcInc = exec && is_inc;
    oFlagsUpdate = exec && is_fu;
    oEof = exec && is_eof;
  end
`ifdef DZCPU_SEQ_BREAKPOINT_EN
  assign oBreak = state == BRK;
`endif
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state <= FETCH;
      oMop <= '0;
      oUopAddr <= '0;
      oOverrun <= 1'b0;
    end else if (!iStall) begin
      case (state)
        FETCH: if (iMopValid) begin
          oMop <= iMopData;
          state <= DECODE;
        end
        DECODE: begin
`ifdef DZCPU_SEQ_BREAKPOINT_EN
          if (iBreakEn && oMop == iBreakMop) state <= BRK;
          else begin
            oUopAddr <= iFlowIdx;
            state <= EXEC;
          end
`else
          oUopAddr <= iFlowIdx;
          state <= EXEC;
`endif
        end
        CBDECODE: begin
          oUopAddr <= iCbFlowIdx;
          state <= EXEC;
        end
        EXEC: if (is_jcb) begin
          oMop <= iMopData;
          state <= CBDECODE;
        end else if (is_eof) begin
          oUopAddr <= '0;
          state <= FETCH;
        end else begin
          oUopAddr <= inc_addr[UPC_W-1:0];
          oOverrun <= oOverrun | inc_addr[UPC_W];
        end
`ifdef DZCPU_SEQ_BREAKPOINT_EN
        BRK: if (iResume) begin
          oUopAddr <= iFlowIdx;
          state <= EXEC;
        end
`endif
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// tb_dzcpu_uop_sequencer: directed plus random checks of dzcpu_uop_sequencer against a behavioural model
module tb_dzcpu_uop_sequencer;
  logic clk = 0, rst_n = 0, stall = 0, mvalid = 0, fz = 0;
  logic [7:0] mdata = 0, mop, uaddr, fidx, cbidx;
  logic [3:0] fctl;
  logic pcinc, fu, uvalid, eof, ovf;
  logic [3:0] rom [256];
  logic [7:0] ftab [256], cbtab [256];
  bit [15:0] inc_set = 16'h017A, fu_set = 16'h0380, eof_set = 16'h018C;
  int total = 0, bad = 0;
  int m_ph;
  logic [7:0] m_mop, m_upc;
  logic m_ovf;
  int n_inc;
  logic [7:0] eof_addr;
  logic fu_eof;
`ifdef DZCPU_SEQ_BREAKPOINT_EN
  logic [7:0] bp_mop = 0;
  logic bp_en = 0, resume = 0, obrk;
`endif
  always #5 clk = ~clk;
  assign fidx = ftab[mop];
  assign cbidx = cbtab[mop];
  assign fctl = rom[uaddr];
  dzcpu_uop_sequencer dut (
    .iClock(clk), .iReset(rst_n), .iStall(stall), .iMopData(mdata), .iMopValid(mvalid),
    .iFlowIdx(fidx), .iCbFlowIdx(cbidx), .iFlowCtl(fctl), .iFlagZ(fz),
    .oMop(mop), .oUopAddr(uaddr), .oPcInc(pcinc), .oFlagsUpdate(fu), .oUopValid(uvalid),
    .oEof(eof), .oOverrun(ovf)
`ifdef DZCPU_SEQ_BREAKPOINT_EN
    , .iBreakMop(bp_mop), .iBreakEn(bp_en), .iResume(resume), .oBreak(obrk)
`endif
  );
  task automatic check(string tag);
    logic [3:0] c;
    logic ex, ze, e_inc, e_fu, e_eof;
    c = rom[m_upc];
    ex = (m_ph == 3) && !stall;
    ze = (c == 4 && fz) || (c == 5 && !fz);
    e_inc = ex && inc_set[c];
    e_fu = ex && fu_set[c];
    e_eof = ex && (eof_set[c] || ze);
    total++;
    assert ({mop, uaddr, pcinc, fu, uvalid, eof, ovf} === {m_mop, m_upc, e_inc, e_fu, ex, e_eof, m_ovf})
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, {mop, uaddr, pcinc, fu, uvalid, eof, ovf},
             {m_mop, m_upc, e_inc, e_fu, ex, e_eof, m_ovf});
    end
`ifdef DZCPU_SEQ_BREAKPOINT_EN
    total++;
    assert (obrk === (m_ph == 4)) else begin
      bad++;
      $error("FAIL %s_brk got=%b exp=%b", tag, obrk, m_ph == 4);
    end
`endif
    n_inc += int'(pcinc);
    if (eof) eof_addr = uaddr;
    if (eof && fu) fu_eof = 1;
  endtask
  task automatic upd();
    logic [3:0] c;
    logic ze, brk_hit;
    c = rom[m_upc];
    ze = (c == 4 && fz) || (c == 5 && !fz);
    brk_hit = 0;
`ifdef DZCPU_SEQ_BREAKPOINT_EN
    brk_hit = bp_en && m_mop == bp_mop;
`endif
    if (!rst_n) begin
      m_ph = 0; m_mop = 0; m_upc = 0; m_ovf = 0;
    end else if (!stall) begin
      if (m_ph == 0) begin
        if (mvalid) begin m_mop = mdata; m_ph = 1; end
      end else if (m_ph == 1) begin
        if (brk_hit) m_ph = 4;
        else begin m_upc = ftab[m_mop]; m_ph = 3; end
      end else if (m_ph == 2) begin
        m_upc = cbtab[m_mop]; m_ph = 3;
      end else if (m_ph == 4) begin
`ifdef DZCPU_SEQ_BREAKPOINT_EN
        if (resume) begin m_upc = ftab[m_mop]; m_ph = 3; end
`endif
      end else if (c == 6) begin
        m_mop = mdata; m_ph = 2;
      end else if (eof_set[c] || ze) begin
        m_upc = 0; m_ph = 0;
      end else begin
        if (m_upc == 8'hFF) m_ovf = 1;
        m_upc = m_upc + 8'd1;
      end
    end
  endtask
  task automatic tick(string tag);
    @(negedge clk);
    check(tag);
    upd();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic fetch_op(logic [7:0] op);
    n_inc = 0; eof_addr = 8'hEE; fu_eof = 0;
    mdata = op; mvalid = 1;
    tick("fetch");
    mvalid = 0;
  endtask
  task automatic finish_flow(string tag);
    int n;
    n = 0;
    while (m_ph != 0 && n < 64) begin tick(tag); n++; end
    expect_eq({tag, "_bound"}, 32'(n < 64), 1);
  endtask
  task automatic run_to(logic [7:0] a);
    int n;
    n = 0;
    while (!(m_ph == 3 && m_upc == a) && n < 64) begin tick("run"); n++; end
    expect_eq("run_to_bound", 32'(n < 64), 1);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin rom[i] = 0; ftab[i] = 0; cbtab[i] = 0; end
    ftab[8'h31] = 1; rom[1] = 1; rom[2] = 1; rom[3] = 0; rom[4] = 3;
    ftab[8'h20] = 17; rom[17] = 0; rom[18] = 1; rom[19] = 4; rom[20] = 0; rom[21] = 0; rom[22] = 3;
    ftab[8'hCB] = 13; rom[13] = 0; rom[14] = 1; rom[15] = 6; cbtab[8'h7C] = 16; rom[16] = 7;
    ftab[8'h40] = 50; rom[53] = 2;
    ftab[8'h50] = 54; rom[59] = 2;
    ftab[8'hFF] = 255; rom[255] = 0; rom[0] = 2;
    ftab[8'hC9] = 83; rom[83] = 3;
    rst_n = 0;
    @(posedge clk); #1;
    m_ph = 0; m_mop = 0; m_upc = 0; m_ovf = 0; n_inc = 0; eof_addr = 0; fu_eof = 0;
    tick("reset");
    expect_eq("reset_state", {mop, uaddr, pcinc, fu, uvalid, eof, ovf}, 0);
    rst_n = 1;
    tick("idle");
    fetch_op(8'h31);
    finish_flow("flow31");
    expect_eq("flow31_pcinc", n_inc, 3);
    expect_eq("flow31_eof_addr", eof_addr, 4);
    expect_eq("flow31_addr0", uaddr, 0);
    fz = 1;
    fetch_op(8'h20);
    finish_flow("jrnz_z1");
    expect_eq("jrnz_z1_eof_addr", eof_addr, 19);
    expect_eq("jrnz_z1_pcinc", n_inc, 2);
    fz = 0;
    fetch_op(8'h20);
    finish_flow("jrnz_z0");
    expect_eq("jrnz_z0_eof_addr", eof_addr, 22);
    expect_eq("jrnz_z0_pcinc", n_inc, 3);
    fetch_op(8'hCB);
    mdata = 8'h7C;
    finish_flow("cb");
    expect_eq("cb_mop", mop, 8'h7C);
    expect_eq("cb_eof_addr", eof_addr, 16);
    expect_eq("cb_fu_eof", 32'(fu_eof), 1);
    fetch_op(8'h40);
    run_to(51);
    stall = 1;
    repeat (3) tick("stall");
    expect_eq("stall_hold", uaddr, 51);
    stall = 0;
    tick("unstall");
    expect_eq("stall_resume", uaddr, 52);
    finish_flow("stall_flow");
    fetch_op(8'h50);
    run_to(55);
    rst_n = 0;
    tick("midreset");
    rst_n = 1;
    expect_eq("midreset_addr", uaddr, 0);
    tick("after_reset");
    fetch_op(8'hFF);
    finish_flow("wrap");
    expect_eq("wrap_overrun", 32'(ovf), 1);
    rst_n = 0;
    tick("wrap_reset");
    rst_n = 1;
    expect_eq("overrun_cleared", 32'(ovf), 0);
`ifdef DZCPU_SEQ_BREAKPOINT_EN
    bp_mop = 8'hC9; bp_en = 1;
    fetch_op(8'hC9);
    repeat (4) tick("break");
    expect_eq("break_flag", 32'(obrk), 1);
    expect_eq("break_addr", uaddr, 0);
    resume = 1;
    tick("resume");
    resume = 0;
    expect_eq("resume_addr", uaddr, 83);
    finish_flow("break_flow");
    bp_en = 0;
`endif
    for (int i = 0; i < 256; i++) begin
      rom[i] = 4'($urandom_range(0, 15));
      ftab[i] = 8'($urandom);
      cbtab[i] = 8'($urandom);
    end
    for (int k = 0; k < 4000; k++) begin
      stall = $urandom_range(0, 3) == 0;
      fz = 1'($urandom);
      mvalid = 1'($urandom);
      mdata = 8'($urandom);
      rst_n = $urandom_range(0, 99) != 0;
`ifdef DZCPU_SEQ_BREAKPOINT_EN
      bp_en = $urandom_range(0, 3) == 0;
      bp_mop = 8'($urandom_range(0, 3)) == 0 ? mop : 8'($urandom);
      resume = 1'($urandom);
`endif
      tick("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dzcpu_uop_sequencer.md
Name: dzcpu_uop_sequencer

Overview:
- Micro-program counter and flow controller for the dzcpu core.
- Latches each fetched opcode byte and presents it to the main and CB opcode-to-flow lookups, then loads the returned flow index as the micro-PC.
- Steps the micro-op ROM address one entry at a time, acting on each micro-op's flow-control field: advance, end-of-flow, conditional end on Z, CB-prefix redirect, flag-update strobe.
- Sits between the opcode lookups (upstream) and the micro-op ROM / datapath (downstream).

Parameters:
- UPC_W, 8, micro-PC / ROM address width.
- FLOW_W, 4, width of the flow-control field from the micro-op.

Ports:
- iClock  in  1  core clock.
- iReset  in  1  synchronous, active-low reset.
- iStall  in  1  memory/datapath not ready; freezes all sequencer state.
- iMopData  in  8  memory read data (opcode or CB byte).
- iMopValid  in  1  iMopData holds a valid opcode this cycle.
- iFlowIdx  in  UPC_W  flow index from the main opcode lookup, driven by oMop.
- iCbFlowIdx  in  UPC_W  flow index from the CB lookup, driven by oMop.
- iFlowCtl  in  FLOW_W  flow field of the micro-op at oUopAddr.
- iFlagZ  in  1  current Z flag.
- oMop  out  8  latched opcode to both lookups.
- oUopAddr  out  UPC_W  micro-op ROM address (micro-PC).
- oPcInc  out  1  one-cycle strobe: increment architectural PC.
- oFlagsUpdate  out  1  one-cycle strobe: commit ALU flags.
- oUopValid  out  1  oUopAddr is executing this cycle (EXEC state, not stalled).
- oEof  out  1  one-cycle strobe: instruction retired.
- oOverrun  out  1  sticky: micro-PC wrapped past 2^UPC_W-1.

Behaviour:
- Reset (iReset==0 at a clock edge): state=FETCH; oMop=8'h00; oUopAddr=0; all strobes, oUopValid and oOverrun =0. Reset overrides stall and aborts any flow in progress.
- Stall: when iStall=1, state, oMop and oUopAddr hold. All strobes and oUopValid are forced to 0.
- Flow codes: 0 OP, 1 INC, 2 EOF, 3 INC_EOF, 4 INC_EOF_Z, 5 INC_EOF_NZ, 6 JCB, 7 EOF_FU, 8 INC_EOF_FU, 9 UPDATE_FLAGS. Codes 10-15 are treated as OP.
- FETCH: wait for iMopValid. On iMopValid, oMop<=iMopData and go to DECODE.
- DECODE, 1 cycle: oUopAddr<=iFlowIdx; go to EXEC.
- CBDECODE, 1 cycle: oUopAddr<=iCbFlowIdx; go to EXEC.
- EXEC: oUopValid=1; decode iFlowCtl combinationally.
  - OP: uPC+1.
  - INC: oPcInc=1, uPC+1.
  - UPDATE_FLAGS: oFlagsUpdate=1, uPC+1.
  - EOF: oEof=1, go to FETCH.
  - INC_EOF: oPcInc=1, oEof=1, go to FETCH.
  - EOF_FU: oFlagsUpdate=1, oEof=1, go to FETCH.
  - INC_EOF_FU: oPcInc=1, oFlagsUpdate=1, oEof=1, go to FETCH.
  - INC_EOF_Z: if iFlagZ then behave as INC_EOF; else oPcInc=1, uPC+1.
  - INC_EOF_NZ: if !iFlagZ then behave as INC_EOF; else oPcInc=1, uPC+1.
  - JCB: oPcInc=1, oMop<=iMopData, go to CBDECODE.
- Latency:
  - Opcode accepted to first micro-op valid: 2 cycles.
  - Single-uop flow: opcode to next FETCH is 3 cycles.
  - CB redirect adds 1 cycle (CBDECODE).
- oUopAddr resets to 0 on return to FETCH.
- Wrap: a uPC+1 from 2^UPC_W-1 gives 0 and sets oOverrun (sticky until reset). Execution continues.
- Lookup miss: iFlowIdx=0 is a legal flow (generic one-byte op); no special handling.
- iMopValid is ignored outside FETCH.

Optional Feature:
- Macro: DZCPU_SEQ_BREAKPOINT_EN.
- Enabled:
  - Added ports: iBreakMop (8, in), iBreakEn (1, in), iResume (1, in), oBreak (1, out).
  - New state BREAK. In DECODE, if iBreakEn and oMop==iBreakMop, go to BREAK instead of loading the flow.
  - In BREAK: oBreak=1, outputs frozen, no strobes.
  - On iResume, load iFlowIdx and go to EXEC.
  - oBreak resets to 0.
- Disabled: none of these ports exist; DECODE always proceeds to EXEC.

Test Plan:
- Reset, then oMop=8'h31 with iFlowIdx=1 and ROM flow codes INC,INC,OP,INC_EOF -> oUopAddr steps 1,2,3,4; oPcInc asserted on 3 cycles; oEof at addr 4; back in FETCH with oUopAddr=0.
- JRNZ flow at idx 17 with iFlagZ=1 at INC_EOF_Z (addr 19) -> oEof and oPcInc in that cycle, no addr 20. Repeat with iFlagZ=0 -> steps 20,21,22, oEof at 22.
- CB: opcode 8'hCB (idx 13), JCB at addr 15 with iMopData=8'h7C, iCbFlowIdx=16 -> oMop=8'h7C, CBDECODE, oUopAddr=16; EOF_FU gives oFlagsUpdate=1 and oEof=1 together.
- Stall: iStall=1 for 3 cycles at addr 51 -> addr holds at 51, no strobes; resumes at 52 after release.
- Reset mid-flow at addr 55 -> next cycle state FETCH, oUopAddr=0, strobes 0; after wrap test (flow starting at 255 with OP) oOverrun=1 is cleared.
- With DZCPU_SEQ_BREAKPOINT_EN: iBreakMop=8'hC9, iBreakEn=1, fetch 8'hC9 -> oBreak=1, addr frozen until iResume; then oUopAddr=83.
